// File: rtl/uart_tx.sv
// UART transmitter: valid/ready word in, start + LSB-first data + optional parity + stop out.
// All outputs are flops so the line never glitches into the receiver's synchroniser.
module uart_tx #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic frame_parity(input logic [DATA_BITS-1:0] d);
    return (PARITY_ODD != 0) ? ~^d : ^d;
  endfunction

  state_t               state, state_n;
  logic [BW-1:0]        baud, baud_n;
  logic [3:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par, par_n;
  logic                 ser_n, ready_n, busy_n, done_n;
  logic                 load, last_clk;

  assign load     = tx_ready && tx_valid;
  assign last_clk = (baud == BAUD_LAST);

  // State and output registers; reset drops the line high at once and loses any word.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= 4'd0;
      shift      <= '0;
      par        <= 1'b0;
      serial_out <= 1'b1;
      tx_ready   <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      par        <= par_n;
      serial_out <= ser_n;
      tx_ready   <= ready_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
    end
  end

  // Next state plus the line level and status flags that the next state implies.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shift_n = shift;
    par_n   = par;
    ser_n   = serial_out;
    case (state)
      IDLE: begin
        ser_n = 1'b1;
        if (load) begin
          state_n = START;
          baud_n  = '0;
          bit_n   = 4'd0;
          shift_n = tx_data;
          par_n   = frame_parity(tx_data);
          ser_n   = 1'b0;
        end else begin
          baud_n = '0;
        end
      end
      START: begin
        if (last_clk) begin
          state_n = DATA;
          baud_n  = '0;
          bit_n   = 4'd0;
          ser_n   = shift[0];
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (last_clk) begin
          baud_n  = '0;
          shift_n = shift >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_n = 4'd0;
            if (PARITY_EN != 0) begin
              state_n = PARITY;
              ser_n   = par;
            end else begin
              state_n = STOP;
              ser_n   = 1'b1;
            end
          end else begin
            bit_n = bit_idx + 4'd1;
            ser_n = shift[1];
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      PARITY: begin
        if (last_clk) begin
          state_n = STOP;
          baud_n  = '0;
          bit_n   = 4'd0;
          ser_n   = 1'b1;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (last_clk) begin
          baud_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_n = 4'd0;
            // A word waiting at the final stop clk starts the next frame with no gap.
            if (load) begin
              state_n = START;
              shift_n = tx_data;
              par_n   = frame_parity(tx_data);
              ser_n   = 1'b0;
            end else begin
              state_n = IDLE;
              ser_n   = 1'b1;
            end
          end else begin
            bit_n = bit_idx + 4'd1;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        bit_n   = 4'd0;
        ser_n   = 1'b1;
      end
    endcase
    done_n  = (state_n == STOP) && (baud_n == BAUD_LAST) && (bit_n == STOP_LAST);
    ready_n = (state_n == IDLE) || done_n;
    busy_n  = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no parity, even, odd) checked every clk
// against per-clk expected line/done values queued at each handshake.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [2:0] v = 3'b000;
  logic [7:0] d [3];
  logic [2:0] ser, rdy, busy, done;

  always #5 clk = ~clk;

  uart_tx dut0 (.clk(clk), .n_rst(n_rst), .tx_data(d[0]), .tx_valid(v[0]), .tx_ready(rdy[0]),
                .serial_out(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) dut1 (.clk(clk), .n_rst(n_rst), .tx_data(d[1]),
                .tx_valid(v[1]), .tx_ready(rdy[1]), .serial_out(ser[1]), .tx_busy(busy[1]),
                .tx_done(done[1]));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) dut2 (.clk(clk), .n_rst(n_rst), .tx_data(d[2]),
                .tx_valid(v[2]), .tx_ready(rdy[2]), .serial_out(ser[2]), .tx_busy(busy[2]),
                .tx_done(done[2]));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int done_cyc = 0;
  int hs_a = 0;
  logic [2:0] rdy_exp = 3'b111;
  logic [2:0] hs = 3'b000;
  // entry = {done, serial} for one clk
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] q2[$];

  task automatic chk(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // mode 0: no parity, 1: even, 2: odd; 10 clks per bit
  task automatic push_frame(input int idx, input logic [7:0] data, input int mode);
    logic b[$];
    logic [1:0] e;
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(data[i]);
    if (mode == 1) b.push_back(^data);
    if (mode == 2) b.push_back(~^data);
    b.push_back(1'b1);
    for (int j = 0; j < b.size(); j++) begin
      for (int c = 0; c < 10; c++) begin
        e = {((j == b.size() - 1) && (c == 9)), b[j]};
        case (idx)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
    end
  endtask

  task automatic check_one(input int idx, input logic present, input logic [1:0] e);
    chk($sformatf("d%0d_serial@%0d", idx, cyc), ser[idx], present ? e[0] : 1'b1);
    chk($sformatf("d%0d_done@%0d", idx, cyc), done[idx], present ? e[1] : 1'b0);
    chk($sformatf("d%0d_busy@%0d", idx, cyc), busy[idx], present);
    chk($sformatf("d%0d_ready@%0d", idx, cyc), rdy[idx], rdy_exp[idx]);
  endtask

  task automatic tick();
    logic [2:0] h;
    logic [1:0] e;
    logic p;
    h = v & rdy_exp;
    @(posedge clk);
    cyc++;
    hs = h;
    if (h[0]) begin
      push_frame(0, d[0], 0);
      hs_cyc = cyc;
    end
    if (h[1]) push_frame(1, d[1], 1);
    if (h[2]) push_frame(2, d[2], 2);
    #1;
    p = (q0.size() > 0); e = 2'b00;
    if (p) e = q0.pop_front();
    rdy_exp[0] = (q0.size() == 0);
    check_one(0, p, e);
    p = (q1.size() > 0); e = 2'b00;
    if (p) e = q1.pop_front();
    rdy_exp[1] = (q1.size() == 0);
    check_one(1, p, e);
    p = (q2.size() > 0); e = 2'b00;
    if (p) e = q2.pop_front();
    rdy_exp[2] = (q2.size() == 0);
    check_one(2, p, e);
    if (done[0] === 1'b1) done_cyc = cyc;
  endtask

  task automatic wait_hs(input int idx, input int max);
    for (int n = 0; n < max; n++) begin
      tick();
      if (hs[idx]) break;
    end
    chk($sformatf("d%0d_handshake_bound", idx), hs[idx], 1'b1);
  endtask

  task automatic run_until_idle(input int max);
    for (int n = 0; n < max; n++) begin
      tick();
      if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) break;
    end
    chk("idle_bound", (q0.size() == 0 && q1.size() == 0 && q2.size() == 0), 1'b1);
    repeat (3) tick();
  endtask

  initial begin
    d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00;

    // 1: reset held while clk and tx_valid toggle
    repeat (3) begin
      @(posedge clk);
      v[0] = ~v[0];
      #1;
      chk("rst_serial", ser[0], 1'b1);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_done", done[0], 1'b0);
    end
    v = 3'b000;
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("rst_ready_after", rdy[0], 1'b1);
    rdy_exp = 3'b111;
    repeat (2) tick();

    // 2: 0xA5, done in the 100th clk of the frame
    d[0] = 8'hA5; v[0] = 1'b1;
    wait_hs(0, 5);
    v[0] = 1'b0;
    run_until_idle(200);
    chk_int("a5_done_latency", done_cyc - hs_cyc, 99);

    // 3: 0x07 with even and odd parity, 110 clks each
    d[1] = 8'h07; d[2] = 8'h07; v[1] = 1'b1; v[2] = 1'b1;
    wait_hs(1, 5);
    v[1] = 1'b0; v[2] = 1'b0;
    run_until_idle(200);

    // 4: back-to-back 0x3C then 0xC3 with tx_valid held
    d[0] = 8'h3C; v[0] = 1'b1;
    wait_hs(0, 5);
    hs_a = hs_cyc;
    d[0] = 8'hC3;
    wait_hs(0, 150);
    v[0] = 1'b0;
    chk_int("b2b_spacing", hs_cyc - hs_a, 100);
    run_until_idle(200);

    // 5: tx_data/tx_valid activity while busy is ignored
    d[0] = 8'h55; v[0] = 1'b1;
    wait_hs(0, 5);
    d[0] = 8'hFF;
    repeat (30) tick();
    v[0] = 1'b0;
    run_until_idle(200);

    // 6: reset during data bit 3 of 0x00, then a clean frame
    d[0] = 8'h00; v[0] = 1'b1;
    wait_hs(0, 5);
    v[0] = 1'b0;
    repeat (45) tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("abort_serial", ser[0], 1'b1);
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    q0.delete(); q1.delete(); q2.delete();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("abort_hold_serial", ser[0], 1'b1);
      chk("abort_hold_done", done[0], 1'b0);
    end
    @(negedge clk);
    n_rst = 1'b1;
    rdy_exp = 3'b111;
    d[0] = 8'h96; v[0] = 1'b1;
    wait_hs(0, 5);
    v[0] = 1'b0;
    run_until_idle(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
